// File: rtl/arm_pkg.sv
// Shared ARM core definitions: ALU command codes, condition-field encodings
// and status-register bit positions.
package arm_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

endpackage

// File: rtl/id_exe_stage_reg_if.sv
// ID->EXE pipeline bundle. master = ID side (drives *_in, observes *_out),
// slave = the stage register (reads *_in, drives *_out).
interface id_exe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
);
    logic              illegal_in;
    logic [3:0]        cond_in;
    logic [3:0]        sr_in;
    logic [3:0]        exe_cmd_in;
    logic              mem_read_in, mem_write_in, wb_en_in, b_in, s_in;
    logic [DATA_W-1:0] pc_in, val_rn_in, val_rm_in;
    logic              imm_in;
    logic [11:0]       shift_op_in;
    logic [23:0]       simm24_in;
    logic [REG_W-1:0]  dest_in, src1_in, src2_in;

    // valid_out marks a live instruction; a bubble has valid_out=0 and all control 0
    logic              valid_out;
    logic [3:0]        exe_cmd_out;
    logic              mem_read_out, mem_write_out, wb_en_out, b_out, s_out;
    logic [DATA_W-1:0] pc_out, val_rn_out, val_rm_out;
    logic              imm_out;
    logic [11:0]       shift_op_out;
    logic [23:0]       simm24_out;
    logic [REG_W-1:0]  dest_out, src1_out, src2_out;

    modport master (
        output illegal_in, cond_in, sr_in, exe_cmd_in, mem_read_in, mem_write_in,
               wb_en_in, b_in, s_in, pc_in, val_rn_in, val_rm_in, imm_in,
               shift_op_in, simm24_in, dest_in, src1_in, src2_in,
        input  valid_out, exe_cmd_out, mem_read_out, mem_write_out, wb_en_out,
               b_out, s_out, pc_out, val_rn_out, val_rm_out, imm_out,
               shift_op_out, simm24_out, dest_out, src1_out, src2_out
    );

    modport slave (
        input  illegal_in, cond_in, sr_in, exe_cmd_in, mem_read_in, mem_write_in,
               wb_en_in, b_in, s_in, pc_in, val_rn_in, val_rm_in, imm_in,
               shift_op_in, simm24_in, dest_in, src1_in, src2_in,
        output valid_out, exe_cmd_out, mem_read_out, mem_write_out, wb_en_out,
               b_out, s_out, pc_out, val_rn_out, val_rm_out, imm_out,
               shift_op_out, simm24_out, dest_out, src1_out, src2_out
    );
endinterface

// File: rtl/cond_check.sv
// ARM condition-field evaluator against {N,Z,C,V}. Purely combinational;
// shared with the branch unit.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] cond_in,
    input  logic [3:0] sr_in,
    output logic       cond_ok
);
    logic n, z, c, v;

    assign n = sr_in[SR_N];
    assign z = sr_in[SR_Z];
    assign c = sr_in[SR_C];
    assign v = sr_in[SR_V];

    always_comb begin
        cond_ok = 1'b0;
        case (cond_e'(cond_in))
            COND_EQ: cond_ok = z;
            COND_NE: cond_ok = ~z;
            COND_CS: cond_ok = c;
            COND_CC: cond_ok = ~c;
            COND_MI: cond_ok = n;
            COND_PL: cond_ok = ~n;
            COND_VS: cond_ok = v;
            COND_VC: cond_ok = ~v;
            COND_HI: cond_ok = c & ~z;
            COND_LS: cond_ok = ~c | z;
            COND_GE: cond_ok = (n == v);
            COND_LT: cond_ok = (n != v);
            COND_GT: cond_ok = ~z & (n == v);
            COND_LE: cond_ok = z | (n != v);
            COND_AL: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end
endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with condition gating, illegal squash, freeze and flush.
// Optional macro KILL_CNT_EN adds a saturating count of bubbles written.
module id_exe_stage_reg
    import arm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        freeze,
    id_exe_stage_reg_if.slave bus,
    output logic [15:0] kill_cnt
);
    logic cond_ok;
    logic pass;

    cond_check u_cond_check (
        .cond_in (bus.cond_in),
        .sr_in   (bus.sr_in),
        .cond_ok (cond_ok)
    );

    // Control inputs are undriven for illegal encodings, so pass gates all of them
    assign pass = cond_ok & ~bus.illegal_in;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            bus.valid_out     <= 1'b0;
            bus.exe_cmd_out   <= '0;
            bus.mem_read_out  <= 1'b0;
            bus.mem_write_out <= 1'b0;
            bus.wb_en_out     <= 1'b0;
            bus.b_out         <= 1'b0;
            bus.s_out         <= 1'b0;
            bus.pc_out        <= '0;
            bus.val_rn_out    <= '0;
            bus.val_rm_out    <= '0;
            bus.imm_out       <= 1'b0;
            bus.shift_op_out  <= '0;
            bus.simm24_out    <= '0;
            bus.dest_out      <= '0;
            bus.src1_out      <= '0;
            bus.src2_out      <= '0;
        end else if (!freeze) begin
            bus.pc_out        <= bus.pc_in;
            bus.val_rn_out    <= bus.val_rn_in;
            bus.val_rm_out    <= bus.val_rm_in;
            bus.imm_out       <= bus.imm_in;
            bus.shift_op_out  <= bus.shift_op_in;
            bus.simm24_out    <= bus.simm24_in;
            bus.dest_out      <= bus.dest_in;
            bus.src1_out      <= bus.src1_in;
            bus.src2_out      <= bus.src2_in;
            bus.valid_out     <= pass;
            bus.exe_cmd_out   <= pass ? bus.exe_cmd_in : 4'b0000;
            bus.mem_read_out  <= pass & bus.mem_read_in;
            bus.mem_write_out <= pass & bus.mem_write_in;
            bus.wb_en_out     <= pass & bus.wb_en_in;
            bus.b_out         <= pass & bus.b_in;
            bus.s_out         <= pass & bus.s_in;
        end
    end

`ifdef KILL_CNT_EN
    logic [15:0] kill_q;
    logic        bubble;

    // A flush overrides freeze, so it always writes a bubble
    assign bubble = flush | (~freeze & ~pass);

    always_ff @(posedge clk) begin
        if (rst) begin
            kill_q <= '0;
        end else if (bubble && kill_q != 16'hFFFF) begin
            kill_q <= kill_q + 16'd1;
        end
    end

    assign kill_cnt = kill_q;
`else
    assign kill_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed bench for id_exe_stage_reg; kill_cnt expectations follow KILL_CNT_EN.
module tb_id_exe_stage_reg;
    localparam int DATA_W = 32;
    localparam int REG_W  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        freeze;
    logic [15:0] kill_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_kill = 0;

    id_exe_stage_reg_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

    id_exe_stage_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .freeze   (freeze),
        .bus      (bus),
        .kill_cnt (kill_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_kc();
`ifdef KILL_CNT_EN
        return exp_kill[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random();
        bus.illegal_in   = 1'($urandom_range(0, 1));
        bus.cond_in      = 4'($urandom_range(0, 15));
        bus.sr_in        = 4'($urandom_range(0, 15));
        bus.exe_cmd_in   = 4'($urandom_range(0, 15));
        bus.mem_read_in  = 1'($urandom_range(0, 1));
        bus.mem_write_in = 1'($urandom_range(0, 1));
        bus.wb_en_in     = 1'($urandom_range(0, 1));
        bus.b_in         = 1'($urandom_range(0, 1));
        bus.s_in         = 1'($urandom_range(0, 1));
        bus.pc_in        = $urandom;
        bus.val_rn_in    = $urandom;
        bus.val_rm_in    = $urandom;
        bus.imm_in       = 1'($urandom_range(0, 1));
        bus.shift_op_in  = 12'($urandom_range(0, 4095));
        bus.simm24_in    = 24'($urandom);
        bus.dest_in      = 4'($urandom_range(0, 15));
        bus.src1_in      = 4'($urandom_range(0, 15));
        bus.src2_in      = 4'($urandom_range(0, 15));
    endtask

    // legal instruction with only the named control bits set
    task automatic drive_instr(input logic [3:0] cond, input logic [3:0] sr,
                               input logic [3:0] cmd, input logic mw, input logic wb,
                               input logic s, input logic [31:0] pc, input logic [3:0] dest);
        drive_random();
        bus.illegal_in   = 1'b0;
        bus.cond_in      = cond;
        bus.sr_in        = sr;
        bus.exe_cmd_in   = cmd;
        bus.mem_read_in  = 1'b0;
        bus.mem_write_in = mw;
        bus.wb_en_in     = wb;
        bus.b_in         = 1'b0;
        bus.s_in         = s;
        bus.pc_in        = pc;
        bus.dest_in      = dest;
    endtask

    logic [3:0]  t_cond [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    logic [3:0]  t_sr   [16] = '{4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b1000, 4'b1000,
                                 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b1000, 4'b1000,
                                 4'b1001, 4'b1001, 4'b0000, 4'b1111};
    logic        t_pass [16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                                 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst = 1'b1; flush = 1'b0; freeze = 1'b0;
        // 1: reset with random inputs
        for (int i = 0; i < 2; i++) begin
            drive_random();
            flush  = 1'($urandom_range(0, 1));
            freeze = 1'($urandom_range(0, 1));
            step();
        end
        check("rst_valid", 32'(bus.valid_out), 0);
        check("rst_exe_cmd", 32'(bus.exe_cmd_out), 0);
        check("rst_wb_en", 32'(bus.wb_en_out), 0);
        check("rst_pc", bus.pc_out, 0);
        check("rst_val_rn", bus.val_rn_out, 0);
        check("rst_kill", 32'(kill_cnt), 0);
        rst = 1'b0; flush = 1'b0; freeze = 1'b0;

        // 2: AL MOV
        drive_instr(4'b1110, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b1, 32'h10, 4'd3);
        bus.val_rn_in = 32'hCAFE_0001;
        step();
        check("al_exe_cmd", 32'(bus.exe_cmd_out), 32'h1);
        check("al_wb_en", 32'(bus.wb_en_out), 1);
        check("al_s", 32'(bus.s_out), 1);
        check("al_dest", 32'(bus.dest_out), 3);
        check("al_pc", bus.pc_out, 32'h10);
        check("al_val_rn", bus.val_rn_out, 32'hCAFE_0001);
        check("al_valid", 32'(bus.valid_out), 1);

        // 3: EQ with Z clear squashes, data still captured
        drive_instr(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h20, 4'd5);
        step(); exp_kill++;
        check("eq0_mem_write", 32'(bus.mem_write_out), 0);
        check("eq0_valid", 32'(bus.valid_out), 0);
        check("eq0_pc", bus.pc_out, 32'h20);
        check("eq0_dest", 32'(bus.dest_out), 5);
        check("eq0_kill", 32'(kill_cnt), 32'(exp_kc()));
        drive_instr(4'b0000, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h24, 4'd6);
        step();
        check("eq1_mem_write", 32'(bus.mem_write_out), 1);
        check("eq1_valid", 32'(bus.valid_out), 1);

        // 4: ADD then freeze with changing inputs, then freeze+flush
        drive_instr(4'b1110, 4'b0000, 4'b0010, 1'b0, 1'b1, 1'b0, 32'h30, 4'd7);
        step();
        check("add_exe_cmd", 32'(bus.exe_cmd_out), 32'h2);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_instr(4'b1110, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b1, 32'h100 + 32'(i), 4'd9);
            step();
            check("frz_exe_cmd", 32'(bus.exe_cmd_out), 32'h2);
            check("frz_pc", bus.pc_out, 32'h30);
            check("frz_valid", 32'(bus.valid_out), 1);
            check("frz_kill", 32'(kill_cnt), 32'(exp_kc()));
        end
        flush = 1'b1;
        step(); exp_kill++;
        check("fl_valid", 32'(bus.valid_out), 0);
        check("fl_exe_cmd", 32'(bus.exe_cmd_out), 0);
        check("fl_wb_en", 32'(bus.wb_en_out), 0);
        check("fl_pc", bus.pc_out, 0);
        check("fl_kill", 32'(kill_cnt), 32'(exp_kc()));
        flush = 1'b0; freeze = 1'b0;

        // 5: illegal squash, NV squash, frozen bubble stays a bubble
        drive_instr(4'b1110, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 32'h40, 4'd1);
        bus.illegal_in = 1'b1;
        step(); exp_kill++;
        check("ill_wb_en", 32'(bus.wb_en_out), 0);
        check("ill_valid", 32'(bus.valid_out), 0);
        check("ill_pc", bus.pc_out, 32'h40);
        drive_instr(4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 32'h44, 4'd2);
        step(); exp_kill++;
        check("nv_valid", 32'(bus.valid_out), 0);
        check("nv_exe_cmd", 32'(bus.exe_cmd_out), 0);
        freeze = 1'b1;
        drive_instr(4'b1110, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 32'h48, 4'd2);
        step();
        check("frzb_valid", 32'(bus.valid_out), 0);
        check("frzb_wb_en", 32'(bus.wb_en_out), 0);
        check("frzb_kill", 32'(kill_cnt), 32'(exp_kc()));
        freeze = 1'b0;

        // 6: full condition table (includes GT pass / LE squash on N=V=1)
        for (int i = 0; i < 16; i++) begin
            drive_instr(t_cond[i], t_sr[i], 4'b1000, 1'b0, 1'b1, 1'b0, 32'h200 + 32'(i), 4'(i));
            step();
            if (!t_pass[i]) exp_kill++;
            check($sformatf("cond%0d_valid", i), 32'(bus.valid_out), 32'(t_pass[i]));
            check($sformatf("cond%0d_wb_en", i), 32'(bus.wb_en_out), 32'(t_pass[i]));
            check($sformatf("cond%0d_exe_cmd", i), 32'(bus.exe_cmd_out),
                  t_pass[i] ? 32'h8 : 32'h0);
        end
        check("tbl_kill", 32'(kill_cnt), 32'(exp_kc()));

`ifdef KILL_CNT_EN
        // saturation
        flush = 1'b1;
        while (exp_kill < 32'hFFFE) begin
            step(); exp_kill++;
        end
        flush = 1'b0;
        check("sat_pre", 32'(kill_cnt), 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            drive_instr(4'b1101, 4'b1001, 4'b0001, 1'b0, 1'b1, 1'b0, 32'h300, 4'd0);
            step();
            check("sat_kill", 32'(kill_cnt), 32'hFFFF);
        end
`endif

        rst = 1'b1;
        step();
        check("rst2_kill", 32'(kill_cnt), 0);
        check("rst2_valid", 32'(bus.valid_out), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
Pipeline register between the ID stage (control unit + register file) and the EXE stage of the 5-stage ARM core. Captures the control unit's outputs (exe_cmd, mem_read_en, mem_write_en, wb_en, b, s) with operands and PC. Applies ARM condition-code gating and illegal-instruction squash, inserting a bubble when either fails. Supports freeze (hazard stall) and flush (taken branch).

Parameters:
DATA_W, 32, width of PC and operand values
REG_W, 4, register index width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
flush  in  1  taken branch in EXE; squash this stage
freeze  in  1  hazard stall; hold contents
illegal_in  in  1  decoder flag: unsupported mode/opcode combination
cond_in  in  4  instruction bits [31:28]
sr_in  in  4  status register {N,Z,C,V}
exe_cmd_in  in  4  ALU command from control unit
mem_read_in, mem_write_in, wb_en_in, b_in, s_in  in  1 each  control unit outputs
pc_in  in  DATA_W  PC+4 of instruction
val_rn_in, val_rm_in  in  DATA_W  register file reads
imm_in  in  1  I bit
shift_op_in  in  12  shifter operand field
simm24_in  in  24  branch offset
dest_in, src1_in, src2_in  in  REG_W  register indices
valid_out  out  1  stage holds a live instruction
exe_cmd_out, mem_read_out, mem_write_out, wb_en_out, b_out, s_out  out  4/1  registered control
pc_out, val_rn_out, val_rm_out, imm_out, shift_op_out, simm24_out, dest_out, src1_out, src2_out  out  as inputs  registered data
kill_cnt  out  16  squash counter (see Optional Feature)

Behaviour:
- All state updates on posedge clk; priority rst > flush > freeze > load.
- rst: every output 0, including valid_out and kill_cnt.
- flush (freeze ignored): all control outputs 0, valid_out 0, data outputs 0.
- freeze, no flush: every output holds its value. A frozen bubble stays a bubble.
- Load: data outputs capture inputs unconditionally.
  - pass = cond_ok(cond_in, sr_in) & ~illegal_in.
  - pass=1: control outputs capture inputs; valid_out 1.
  - pass=0: exe_cmd_out 0, mem_read/mem_write/wb_en/b/s 0, valid_out 0.
- cond_ok is combinational, standard ARM table on sr_in = {N,Z,C,V}:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; 1111 treated as 0 (squash)
- sr_in is sampled in the same cycle as the instruction. Flag forwarding from EXE is not this block's responsibility.
- Latency: exactly one cycle from inputs to outputs when not frozen.
- Control inputs are never trusted when illegal_in=1, because the control unit leaves them undriven for illegal combinations.

Optional Feature:
KILL_CNT_EN
- Defined:
  - kill_cnt increments by 1 on each non-frozen, non-reset edge where a bubble is written, i.e. flush=1, or load with pass=0.
  - Saturates at 16'hFFFF; cleared only by rst.
  - A frozen cycle never counts.
- Undefined: kill_cnt tied to 0; no counter flops.

Decomposition:
- Shared package arm_pkg holds:
  - exe_cmd codes: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000
  - cond encodings EQ..AL/NV
  - SR bit indices N=3, Z=2, C=1, V=0
- One sub-module, cond_check: inputs cond_in and sr_in, output cond_ok; purely combinational, reused later by the branch unit.

Test Plan:
1. rst=1 for 2 cycles with random inputs -> all outputs 0, kill_cnt 0.
2. cond=AL(1110), exe_cmd=0001, wb_en=1, s=1, dest=4'd3, pc=32'h10 -> next cycle exe_cmd_out=0001, wb_en_out=1, s_out=1, dest_out=3, pc_out=32'h10, valid_out=1.
3. cond=EQ(0000), sr=4'b0000, mem_write=1 -> mem_write_out=0, valid_out=0, data captured, kill_cnt=1 (with KILL_CNT_EN). Same with sr=4'b0100 -> mem_write_out=1.
4. Load valid ADD (exe_cmd=0010), then freeze=1 for 3 cycles with changing inputs -> outputs stay ADD/0010 throughout; then freeze=flush=1 -> outputs 0, valid_out 0.
5. illegal_in=1, cond=AL, wb_en_in=1 -> wb_en_out=0, valid_out=0. cond=1111 with legal instruction -> squash.
6. GT with sr=4'b1001 (N=V=1, Z=0) -> pass; LE with same flags -> squash. With KILL_CNT_EN preloaded near 16'hFFFF, further squashes -> kill_cnt holds 16'hFFFF.
